// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin arbiter granting two requesters push/pop/tos access to an external stack.
module stack_arbiter #(
  parameter int DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       r0_req_i,
  input  logic       r1_req_i,
  input  logic [1:0] r0_op_i,
  input  logic [1:0] r1_op_i,
  input  logic [7:0] r0_wdata_i,
  input  logic [7:0] r1_wdata_i,
  output logic       r0_done_o,
  output logic       r1_done_o,
  output logic       r0_err_o,
  output logic       r1_err_o,
  output logic [7:0] rdata_o,
  output logic       stk_push_o,
  output logic       stk_pop_o,
  output logic       stk_tos_o,
  output logic [7:0] stk_din_o,
  input  logic [7:0] stk_dout_i,
  output logic [3:0] count_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);
  logic [1:0] state_q, state_d, op_q;
  logic       gnt_q, last_q, ok_q, any_req, win, ok, issue, in_done, rd_ok;
  logic [7:0] wdata_q, rdata_q;
  logic [3:0] cnt_q, cnt_d;
  assign any_req = r0_req_i | r1_req_i;
  // on a tie the requester not granted last wins; a lone requester always wins
  assign win     = (r0_req_i & r1_req_i) ? ~last_q : r1_req_i;
  assign issue   = state_q == ISSUE;
  assign in_done = state_q == DONE;
  assign ok      = op_q == 2'b00 ? cnt_q != DEPTH_C : op_q != 2'b11 && cnt_q != 4'd0;
  assign stk_push_o = issue & ok & (op_q == 2'b00);
  assign stk_pop_o  = issue & ok & (op_q == 2'b01);
  assign stk_tos_o  = issue & ok & (op_q == 2'b10);
  assign stk_din_o  = wdata_q;
  assign r0_done_o  = in_done & ~gnt_q;
  assign r1_done_o  = in_done & gnt_q;
  assign r0_err_o   = r0_done_o & ~ok_q;
  assign r1_err_o   = r1_done_o & ~ok_q;
  // stack output is only fresh in DONE, so legal reads pass it straight through
  assign rd_ok   = in_done & ok_q & (op_q != 2'b00);
  assign rdata_o = rd_ok ? stk_dout_i : rdata_q;
  assign count_o = cnt_q;
  assign full_o  = cnt_q == DEPTH_C;
  assign empty_o = cnt_q == 4'd0;
  always_comb begin
    state_d = state_q == IDLE ? (any_req ? ISSUE : IDLE) : issue ? DONE : IDLE;
    cnt_d   = stk_push_o ? cnt_q + 4'd1 : stk_pop_o ? cnt_q - 4'd1 : cnt_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      ok_q    <= 1'b0;
      op_q    <= 2'b00;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_o;
      if (state_q == IDLE && any_req) begin
        gnt_q   <= win;
        last_q  <= win;
        op_q    <= win ? r1_op_i : r0_op_i;
        wdata_q <= win ? r1_wdata_i : r0_wdata_i;
      end
      if (issue) ok_q <= ok;
    end
  end
endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: directed-vector bench for stack_arbiter with a small behavioural stack attached.
module tb_stack_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       r0_req = 1'b0, r1_req = 1'b0;
  logic [1:0] r0_op = 2'b00, r1_op = 2'b00;
  logic [7:0] r0_wd = 8'h00, r1_wd = 8'h00;
  logic       r0_done, r1_done, r0_err, r1_err;
  logic [7:0] rdata, stk_din, stk_dout;
  logic       stk_push, stk_pop, stk_tos, full, empty;
  logic [3:0] count, sp;
  logic [7:0] mem [0:15];
  int n_chk = 0, n_fail = 0;

  stack_arbiter #(.DEPTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .r0_req_i(r0_req), .r1_req_i(r1_req),
    .r0_op_i(r0_op), .r1_op_i(r1_op),
    .r0_wdata_i(r0_wd), .r1_wdata_i(r1_wd),
    .r0_done_o(r0_done), .r1_done_o(r1_done),
    .r0_err_o(r0_err), .r1_err_o(r1_err),
    .rdata_o(rdata),
    .stk_push_o(stk_push), .stk_pop_o(stk_pop), .stk_tos_o(stk_tos),
    .stk_din_o(stk_din), .stk_dout_i(stk_dout),
    .count_o(count), .full_o(full), .empty_o(empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= 4'd0;
      stk_dout <= 8'h00;
    end else if (stk_push) begin
      mem[sp] <= stk_din;
      sp <= sp + 4'd1;
      stk_dout <= stk_din;
    end else if (stk_pop) begin
      stk_dout <= mem[sp - 4'd1];
      sp <= sp - 4'd1;
    end else if (stk_tos) begin
      stk_dout <= mem[sp - 4'd1];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    r0_req = 1'b0;
    r1_req = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic op_chk(input string tag, input int r, input logic [1:0] op, input logic [7:0] d,
                        input logic [2:0] e_strb, input logic e_err, input logic [7:0] e_rd,
                        input logic [3:0] e_cnt);
    int scyc = -1, dcyc = -1;
    logic [2:0] strb = 3'b000;
    logic [7:0] din = 8'h00, rd = 8'h00;
    logic err = 1'b0, other = 1'b0;
    if (r == 0) begin r0_req = 1'b1; r0_op = op; r0_wd = d; end
    else begin r1_req = 1'b1; r1_op = op; r1_wd = d; end
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (stk_push | stk_pop | stk_tos) begin
        scyc = c;
        strb = {stk_push, stk_pop, stk_tos};
        din = stk_din;
      end
      if (r == 0 ? r0_done : r1_done) begin
        dcyc = c;
        err = r == 0 ? r0_err : r1_err;
        other = r == 0 ? (r1_done | r1_err) : (r0_done | r0_err);
        rd = rdata;
        break;
      end
    end
    r0_req = 1'b0;
    r1_req = 1'b0;
    @(negedge clk);
    check({tag, "_strobe"}, strb, e_strb);
    check({tag, "_strobe_cyc"}, scyc, e_strb != 3'b000 ? 1 : -1);
    check({tag, "_done_cyc"}, dcyc, 2);
    check({tag, "_err"}, err, e_err);
    check({tag, "_other"}, other, 1'b0);
    check({tag, "_rdata"}, rd, e_rd);
    check({tag, "_count"}, count, e_cnt);
    if (e_strb == 3'b100) check({tag, "_din"}, din, d);
  endtask

  initial begin
    int who[4], when[4], nd, seen;
    logic bad_err;
    do_reset();
    check("rst_count", count, 4'd0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_done", {r0_done, r1_done, r0_err, r1_err}, 4'b0000);
    check("rst_strobes", {stk_push, stk_pop, stk_tos}, 3'b000);
    check("rst_rdata", rdata, 8'h00);

    op_chk("push_a5", 0, 2'b00, 8'hA5, 3'b100, 1'b0, 8'h00, 4'd1);
    op_chk("pop_a5", 0, 2'b01, 8'h00, 3'b010, 1'b0, 8'hA5, 4'd0);
    op_chk("push_11", 0, 2'b00, 8'h11, 3'b100, 1'b0, 8'hA5, 4'd1);
    op_chk("push_22", 0, 2'b00, 8'h22, 3'b100, 1'b0, 8'hA5, 4'd2);
    op_chk("tos_r1", 1, 2'b10, 8'h00, 3'b001, 1'b0, 8'h22, 4'd2);
    op_chk("pop_r1", 1, 2'b01, 8'h00, 3'b010, 1'b0, 8'h22, 4'd1);
    op_chk("pop_11", 0, 2'b01, 8'h00, 3'b010, 1'b0, 8'h11, 4'd0);
    op_chk("pop_empty", 0, 2'b01, 8'h00, 3'b000, 1'b1, 8'h11, 4'd0);
    op_chk("illegal_op", 0, 2'b11, 8'h00, 3'b000, 1'b1, 8'h11, 4'd0);
    op_chk("tos_empty", 1, 2'b10, 8'h00, 3'b000, 1'b1, 8'h11, 4'd0);
    check("empty_flag", empty, 1'b1);

    for (int i = 0; i < 8; i++)
      op_chk($sformatf("fill%0d", i), i % 2, 2'b00, 8'h30 + 8'(i), 3'b100, 1'b0, 8'h11, 4'(i + 1));
    check("full_flag", full, 1'b1);
    op_chk("push_full", 1, 2'b00, 8'hEE, 3'b000, 1'b1, 8'h11, 4'd8);
    op_chk("tos_full", 0, 2'b10, 8'h00, 3'b001, 1'b0, 8'h37, 4'd8);

    // both requesters held: grants must alternate starting with r0 after reset
    do_reset();
    for (int k = 0; k < 4; k++) begin who[k] = -1; when[k] = -1; end
    nd = 0;
    bad_err = 1'b0;
    r0_req = 1'b1; r0_op = 2'b00; r0_wd = 8'hA0;
    r1_req = 1'b1; r1_op = 2'b00; r1_wd = 8'hB0;
    for (int c = 1; c <= 14 && nd < 4; c++) begin
      @(negedge clk);
      if (r0_done | r1_done) begin
        who[nd] = r1_done ? 1 : 0;
        when[nd] = c;
        bad_err |= r0_err | r1_err | (r0_done & r1_done);
        nd++;
      end
    end
    r0_req = 1'b0;
    r1_req = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr_who%0d", k), who[k], k % 2);
      check($sformatf("rr_when%0d", k), when[k], 2 + 3 * k);
    end
    check("rr_err", bad_err, 1'b0);
    check("rr_count", count, 4'd4);
    op_chk("rr_tos", 0, 2'b10, 8'h00, 3'b001, 1'b0, 8'hB0, 4'd4);

    // asynchronous reset while a push strobe is on the bus
    r0_req = 1'b1; r0_op = 2'b00; r0_wd = 8'h5A;
    @(posedge clk);
    #1;
    check("mid_push_strobe", stk_push, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_strobe", {stk_push, stk_pop, stk_tos}, 3'b000);
    check("mid_rst_count", count, 4'd0);
    check("mid_rst_rdata", rdata, 8'h00);
    check("mid_rst_done", {r0_done, r0_err}, 2'b00);
    @(negedge clk);
    r0_req = 1'b0;
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (r0_done | r1_done | stk_push) seen++;
    end
    check("post_rst_quiet", seen, 0);
    check("post_rst_count", count, 4'd0);
    check("post_rst_empty", empty, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stack_arbiter.md
STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 Parameter DEPTH, default 8, meaning stack capacity in entries; the legal range is 1..15.
REQ-002 The clk input shall be 1 bit wide and is the single clock; all state updates on its rising edge.
REQ-003 The rst input shall be 1 bit wide, asynchronous and active-low (rst=0 resets).
REQ-004 The r0_req and r1_req inputs shall each be 1 bit wide; each is a request from requester 0 or 1, held until the matching done.
REQ-005 The r0_op and r1_op inputs shall each be 2 bits wide: 00 push, 01 pop, 10 tos, 11 illegal.
REQ-006 The r0_wdata and r1_wdata inputs shall each be 8 bits wide and carry the push data, held with req.
REQ-007 The r0_done and r1_done outputs shall each be 1 bit wide; each is a one-cycle completion pulse to its requester.
REQ-008 The r0_err and r1_err outputs shall each be 1 bit wide; each is valid only with done, and means the operation was rejected.
REQ-009 The rdata output shall be 8 bits wide and carry pop/tos result data, valid with done.
REQ-010 The stk_push, stk_pop and stk_tos outputs shall each be 1 bit wide; each is a one-cycle strobe to the stack.
REQ-011 The stk_din output shall be 8 bits wide and carry the data to the stack.
REQ-012 The stk_dout input shall be 8 bits wide; it is the stack's registered output, updated on the strobe edge.
REQ-013 The count output shall be 4 bits wide and give current occupancy; full and empty shall be 1-bit outputs giving count==DEPTH and count==0.

Function
REQ-014 The FSM shall have three states: IDLE, ISSUE and DONE; the transitions shall be IDLE->ISSUE on any req, ISSUE->DONE always, and DONE->IDLE always.
REQ-015 In IDLE, the block shall latch the grant, op and wdata of the winning requester at the edge that leaves IDLE.
REQ-016 Arbitration shall be round-robin: when both requesters request, the grant shall go to the one not granted last; a single requester shall always win.
REQ-017 The last-granted pointer shall update only on a grant.
REQ-018 In ISSUE, exactly one stk_* strobe shall be high for one cycle, selected by the latched op; stk_din shall equal the latched wdata during ISSUE.
REQ-019 A push when full, a pop or tos when empty, or op 11 shall be rejected: no strobe in ISSUE, count unchanged, and err=1 with done.
REQ-020 count shall increment at the ISSUE edge on a legal push and decrement at the ISSUE edge on a legal pop; tos shall not change count.
REQ-021 In DONE, the granted requester's done shall be 1 for exactly one cycle, and the other requester's done and err shall be 0.
REQ-022 In DONE, rdata shall equal stk_dout for a legal pop/tos; rdata shall hold its previous value for push and rejected ops.
REQ-023 Latency shall be req sampled at edge N, strobe in cycle N+1, done in cycle N+2; back-to-back throughput is one op per 3 cycles.
REQ-024 A requester keeping req high in the cycle after done shall be treated as a new request.
REQ-025 A req deasserted before done is a protocol violation; the block shall complete the latched op regardless.
REQ-026 stk_push, stk_pop and stk_tos shall never be asserted together; no strobe shall be asserted outside ISSUE.

Reset
REQ-027 rst=0 shall force the FSM to IDLE, count=0, the last-granted pointer to r1 (so r0 wins the first tie), rdata=0, and all done, err and stk_* outputs to 0, immediately and without a clock.
REQ-028 Reset mid-operation shall abort the operation with no done; a strobe already issued in ISSUE is not undone, and the stack is reset by the same rst net.
REQ-029 After rst returns to 1, the block shall sample requests from the first following rising edge.

Verification
REQ-030 r0 pushes 0xA5 -> stk_push for 1 cycle with stk_din=0xA5, r0_done 2 cycles after request, r0_err=0, count=1.
REQ-031 After pushes 0x11 and 0x22, r1 tos then pop -> rdata=0x22 both times, count 2->2->1.
REQ-032 Pop with count=0 -> no strobe, r0_done=1 with r0_err=1, count stays 0; op 11 -> same error response.
REQ-033 Pushes to count=DEPTH, then another push -> full=1, err=1, no stk_push, count=DEPTH.
REQ-034 r0_req and r1_req held high continuously -> grants alternate r0, r1, r0, r1, with done every 3 cycles.
REQ-035 rst=0 asserted during ISSUE of a push -> outputs zeroed asynchronously, no done; after release, count=0 and empty=1.
